// File: rtl/wbm_spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wbm_spi_pkg                                                   |
// | Purpose  : Shared definitions for the SPI byte engine: FSM encoding,    |
// |            SPI mode constant and default widths.                         |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package wbm_spi_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DIV_W_DEF  = 8;

  // {CPOL, CPHA}: clock idles low, data sampled on the rising edge.
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/wbm_spi_clkgen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wbm_spi_clkgen                                                |
// | Purpose  : Half-period divider. Latches the divider value on load and   |
// |            emits a 1-cycle tick every (div+1) clocks while run is high. |
// | Ports    : wb_clk_i, wb_rst_i (async, active-high), load, div, run,      |
// |            tick (combinational, 1 cycle per half-period)                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module wbm_spi_clkgen
  import wbm_spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic             run,
  output logic             tick
);

  logic [DIV_W-1:0] divlat;
  logic [DIV_W-1:0] divcnt;

  // The half-period ends on the cycle the counter reaches zero.
  assign tick = run && (divcnt == '0);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      divlat <= '0;
      divcnt <= '0;
    end else if (load) begin
      divlat <= div;
      divcnt <= div;
    end else if (run) begin
      if (divcnt == '0) begin
        divcnt <= divlat;
      end else begin
        divcnt <= divcnt - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wbm_spi_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wbm_spi_master                                                |
// | Purpose  : SPI mode-0 byte engine. Shifts one DATA_W word MSB-first,    |
// |            returns the received word and busy/done/overrun status.      |
// | Ports    : wb_clk_i, wb_rst_i (async, active-high)                       |
// |            spi_en_i, spi_div_i, tx_we_i, tx_dat_i, cs_we_i, cs_val_i,    |
// |            ovr_clr_i, spi_di_i                                           |
// |            spi_sel_o, spi_clk_o, spi_do_o, rx_dat_o, busy_o, done_o,     |
// |            ovr_o (all registered)                                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module wbm_spi_master
  import wbm_spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              spi_en_i,
  input  logic [DIV_W-1:0]  spi_div_i,
  input  logic              tx_we_i,
  input  logic [DATA_W-1:0] tx_dat_i,
  input  logic              cs_we_i,
  input  logic              cs_val_i,
  input  logic              ovr_clr_i,
  input  logic              spi_di_i,
  output logic              spi_sel_o,
  output logic              spi_clk_o,
  output logic              spi_do_o,
  output logic [DATA_W-1:0] rx_dat_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovr_o
);

  localparam int   CNT_W = $clog2(DATA_W);
  localparam logic CPOL  = SPI_MODE0[1];

  spi_state_e        state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]  bitcnt, bitcnt_nxt;
  logic              sel_nxt, sclk_nxt, do_nxt, busy_nxt, done_nxt, ovr_nxt;
  logic [DATA_W-1:0] rx_nxt;
  logic              start, tick;

  assign start = (state == ST_IDLE) && tx_we_i && spi_en_i;

  wbm_spi_clkgen #(
    .DIV_W (DIV_W)
  ) u_clkgen (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .load     (start),
    .div      (spi_div_i),
    .run      (state != ST_IDLE),
    .tick     (tick)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      spi_sel_o <= 1'b1;
      spi_clk_o <= CPOL;
      spi_do_o  <= 1'b0;
      rx_dat_o  <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      ovr_o     <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bitcnt    <= bitcnt_nxt;
      spi_sel_o <= sel_nxt;
      spi_clk_o <= sclk_nxt;
      spi_do_o  <= do_nxt;
      rx_dat_o  <= rx_nxt;
      busy_o    <= busy_nxt;
      done_o    <= done_nxt;
      ovr_o     <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    sel_nxt    = spi_sel_o;
    sclk_nxt   = spi_clk_o;
    do_nxt     = spi_do_o;
    rx_nxt     = rx_dat_o;
    busy_nxt   = busy_o;
    done_nxt   = 1'b0;
    ovr_nxt    = ovr_o;

    // Chip select is pure software control, independent of the FSM.
    if (cs_we_i) begin
      sel_nxt = cs_val_i;
    end

    // Set has priority over clear so a collision is never lost.
    if (tx_we_i && busy_o) begin
      ovr_nxt = 1'b1;
    end else if (ovr_clr_i) begin
      ovr_nxt = 1'b0;
    end

    case (state)
      ST_IDLE: begin
        if (start) begin
          shreg_nxt  = tx_dat_i;
          do_nxt     = tx_dat_i[DATA_W-1];
          bitcnt_nxt = CNT_W'(DATA_W - 1);
          busy_nxt   = 1'b1;
          state_nxt  = ST_LOW;
        end
      end
      ST_LOW, ST_HIGH: begin
        if (!spi_en_i) begin
          // Abort: drop SCLK, no done pulse, RX word left untouched.
          sclk_nxt  = CPOL;
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end else if (tick) begin
          if (state == ST_LOW) begin
            // Rising edge: sample MISO into the vacated LSB.
            sclk_nxt  = ~CPOL;
            shreg_nxt = {shreg[DATA_W-2:0], spi_di_i};
            state_nxt = ST_HIGH;
          end else begin
            sclk_nxt = CPOL;
            if (bitcnt != '0) begin
              do_nxt     = shreg[DATA_W-1];
              bitcnt_nxt = bitcnt - 1'b1;
              state_nxt  = ST_LOW;
            end else begin
              rx_nxt    = shreg;
              done_nxt  = 1'b1;
              busy_nxt  = 1'b0;
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_wbm_spi_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_wbm_spi_master                                             |
// | Purpose  : Self-checking bench for wbm_spi_master with a transfer-level |
// |            reference model and directed plus randomized stimulus.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_wbm_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] div = 8'd0;
  logic       tx_we = 1'b0;
  logic [7:0] tx_dat = 8'd0;
  logic       cs_we = 1'b0;
  logic       cs_val = 1'b1;
  logic       ovr_clr = 1'b0;
  logic       di;
  logic       spi_sel, spi_clk, spi_do, busy, done, ovr;
  logic [7:0] rx_dat;

  logic       loop_mode = 1'b0;
  logic       drive_bit = 1'b0;
  logic [7:0] mbyte = 8'd0;

  assign di = loop_mode ? spi_do : drive_bit;

  always #5 clk = ~clk;

  wbm_spi_master dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .spi_en_i  (en),
    .spi_div_i (div),
    .tx_we_i   (tx_we),
    .tx_dat_i  (tx_dat),
    .cs_we_i   (cs_we),
    .cs_val_i  (cs_val),
    .ovr_clr_i (ovr_clr),
    .spi_di_i  (di),
    .spi_sel_o (spi_sel),
    .spi_clk_o (spi_clk),
    .spi_do_o  (spi_do),
    .rx_dat_o  (rx_dat),
    .busy_o    (busy),
    .done_o    (done),
    .ovr_o     (ovr)
  );

  int total = 0;
  int bad   = 0;
  int rises = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: k = clocks since the start edge, H = half-period.
  // After k clocks, n = k/H half-periods are complete; SCLK is high for odd n,
  // MOSI carries bit n/2 (MSB first), and the transfer ends at n = 16.
  bit         m_act = 0;
  int         m_k = 0, m_h = 1;
  logic [7:0] m_tx = 0, m_rxacc = 0, m_rx = 0;
  logic       m_sel = 1, m_clk = 0, m_do = 0, m_busy = 0, m_done = 0, m_ovr = 0;

  task automatic model_step();
    int n;
    if (rst) begin
      m_act = 0; m_rx = 0; m_sel = 1; m_clk = 0; m_do = 0;
      m_busy = 0; m_done = 0; m_ovr = 0;
    end else begin
      m_done = 0;
      if (tx_we && m_busy) m_ovr = 1;
      else if (ovr_clr)    m_ovr = 0;
      if (cs_we) m_sel = cs_val;
      if (m_act) begin
        if (!en) begin
          m_act = 0; m_busy = 0; m_clk = 0;
        end else begin
          m_k++;
          n = m_k / m_h;
          if ((m_k % m_h == 0) && (n % 2 == 1)) m_rxacc = {m_rxacc[6:0], di};
          if (m_k == 16 * m_h) begin
            m_act = 0; m_busy = 0; m_done = 1; m_rx = m_rxacc; m_clk = 0;
          end else begin
            m_clk = (n % 2 == 1);
            m_do  = m_tx[7 - n / 2];
          end
        end
      end else if (tx_we && en) begin
        m_act = 1; m_k = 0; m_h = int'(div) + 1; m_tx = tx_dat;
        m_busy = 1; m_do = tx_dat[7]; m_rxacc = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // Per-cycle compare and MISO driver (bit j presented before rising edge j).
  initial begin
    logic prev_clk;
    prev_clk = 1'b0;
    forever begin
      @(negedge clk);
      if (m_act) drive_bit = mbyte[7 - (m_k / m_h) / 2];
      if (spi_clk === 1'b1 && prev_clk === 1'b0) rises++;
      prev_clk = spi_clk;
      chk("cyc_sclk", spi_clk, m_clk);
      chk("cyc_mosi", spi_do,  m_do);
      chk("cyc_sel",  spi_sel, m_sel);
      chk("cyc_busy", busy,    m_busy);
      chk("cyc_done", done,    m_done);
      chk("cyc_ovr",  ovr,     m_ovr);
      chk("cyc_rx",   rx_dat,  m_rx);
    end
  end

  task automatic strobe(input logic [7:0] d, input logic [7:0] t);
    @(negedge clk); #1;
    div = d; tx_dat = t; tx_we = 1'b1;
    @(negedge clk); #1;
    tx_we = 1'b0;
  endtask

  task automatic cs_write(input logic v);
    @(negedge clk); #1;
    cs_we = 1'b1; cs_val = v;
    @(negedge clk); #1;
    cs_we = 1'b0;
  endtask

  // Counts clocks until done_o, optionally injecting random side traffic.
  task automatic wait_done(input int exp, input string name, input bit rnd);
    int cnt;
    cnt = 0;
    while (cnt < 5000) begin
      @(negedge clk); #1;
      cs_we = 1'b0; ovr_clr = 1'b0; tx_we = 1'b0;
      cnt++;
      if (done === 1'b1) break;
      if (rnd) begin
        if ($urandom_range(0, 15) == 0) begin cs_we = 1'b1; cs_val = 1'($urandom_range(0, 1)); end
        if ($urandom_range(0, 15) == 0) ovr_clr = 1'b1;
        if ($urandom_range(0, 31) == 0) begin tx_we = 1'b1; tx_dat = 8'($urandom); end
        if ($urandom_range(0, 15) == 0) div = 8'($urandom);
      end
    end
    chk(name, cnt, exp);
  endtask

  initial begin
    int r0;
    repeat (3) @(negedge clk);
    chk("rst_sel",  spi_sel, 1'b1);
    chk("rst_sclk", spi_clk, 1'b0);
    chk("rst_mosi", spi_do,  1'b0);
    chk("rst_rx",   rx_dat,  8'h00);
    chk("rst_busy", busy,    1'b0);
    chk("rst_done", done,    1'b0);
    chk("rst_ovr",  ovr,     1'b0);
    #1 rst = 1'b0;

    // Start ignored while disabled, and no overrun.
    strobe(8'd0, 8'hFF);
    chk("dis_busy", busy, 1'b0);
    en = 1'b1;
    cs_write(1'b0);

    // 1: div=0, loopback.
    loop_mode = 1'b1;
    r0 = rises;
    strobe(8'd0, 8'hA5);
    wait_done(16, "t1_latency", 0);
    chk("t1_rx", rx_dat, 8'hA5);
    chk("t1_rises", rises - r0, 8);

    // 2: div=3, model-driven MISO.
    loop_mode = 1'b0;
    mbyte = 8'hC3;
    strobe(8'd3, 8'h3C);
    wait_done(64, "t2_latency", 0);
    chk("t2_rx", rx_dat, 8'hC3);

    // 3: second start at clock 5 -> overrun, first transfer unaltered.
    mbyte = 8'h5A;
    strobe(8'd0, 8'h81);
    repeat (4) begin @(negedge clk); #1; end
    tx_we = 1'b1; tx_dat = 8'hFF;
    @(negedge clk); #1;
    tx_we = 1'b0;
    chk("t3_ovr_set", ovr, 1'b1);
    wait_done(11, "t3_latency", 0);
    chk("t3_rx", rx_dat, 8'h5A);
    @(negedge clk); #1; ovr_clr = 1'b1;
    @(negedge clk); #1; ovr_clr = 1'b0;
    chk("t3_ovr_clr", ovr, 1'b0);
    chk("t3_idle", busy, 1'b0);

    // Set beats clear in the same cycle.
    mbyte = 8'h22;
    strobe(8'd1, 8'h11);
    tx_we = 1'b1; ovr_clr = 1'b1;
    @(negedge clk); #1;
    tx_we = 1'b0; ovr_clr = 1'b1;
    chk("setwins_ovr", ovr, 1'b1);
    @(negedge clk); #1;
    ovr_clr = 1'b0;
    chk("setwins_clr", ovr, 1'b0);
    wait_done(30, "setwins_latency", 0);
    chk("setwins_rx", rx_dat, 8'h22);

    // Start in the done cycle is accepted (engine already idle).
    mbyte = 8'hE7;
    div = 8'd0; tx_dat = 8'h0F; tx_we = 1'b1;
    @(negedge clk); #1;
    tx_we = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_ovr", ovr, 1'b0);
    wait_done(16, "b2b_latency", 0);
    chk("b2b_rx", rx_dat, 8'hE7);

    // 4: abort after 3 SCLK rises (H=2 -> third rise at clock 10).
    mbyte = 8'h00;
    strobe(8'd1, 8'hF0);
    repeat (10) begin @(negedge clk); #1; end
    chk("t4_sclk_hi", spi_clk, 1'b1);
    en = 1'b0;
    @(negedge clk); #1;
    chk("t4_busy", busy, 1'b0);
    chk("t4_sclk", spi_clk, 1'b0);
    chk("t4_sel", spi_sel, 1'b0);
    repeat (3) begin
      @(negedge clk); #1;
      chk("t4_nodone", done, 1'b0);
    end
    chk("t4_rx", rx_dat, 8'hE7);
    en = 1'b1;

    // 5: divider change mid-transfer only affects the next transfer.
    mbyte = 8'hAA;
    strobe(8'd1, 8'h55);
    div = 8'd7;
    @(negedge clk); #1;
    wait_done(31, "t5_latency_a", 0);
    chk("t5_rx_a", rx_dat, 8'hAA);
    mbyte = 8'h3D;
    strobe(8'd7, 8'h96);
    wait_done(128, "t5_latency_b", 0);
    chk("t5_rx_b", rx_dat, 8'h3D);

    // 6: async reset in the middle of a HIGH phase.
    strobe(8'd3, 8'h99);
    repeat (5) begin @(negedge clk); #1; end
    chk("t6_sclk_hi", spi_clk, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_sclk", spi_clk, 1'b0);
    chk("t6_sel", spi_sel, 1'b1);
    chk("t6_busy", busy, 1'b0);
    @(negedge clk); #1;
    rst = 1'b0;

    // Randomized transfers with side traffic.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] d, t;
      logic       lp;
      d = 8'($urandom_range(0, 5));
      t = 8'($urandom);
      lp = 1'($urandom_range(0, 1));
      mbyte = 8'($urandom);
      loop_mode = lp;
      strobe(d, t);
      wait_done(16 * (int'(d) + 1), "rnd_latency", 1);
      chk("rnd_rx", rx_dat, lp ? t : mbyte);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
